mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, default 4, cycles from issue to completion of a write at main memory (legal 2..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-side read request; held until accepted.
REQ-005 i_addr  input  16  instruction-side read address.
REQ-006 i_ready  output  1  instruction request accepted this cycle (transfer on i_req & i_ready).
REQ-007 i_valid  output  1  one-cycle pulse: i_rdata valid.
REQ-008 i_rdata  output  16  instruction-side read data.
REQ-009 d_req  input  1  data-side request; held until accepted.
REQ-010 d_wr  input  1  data-side write when 1, read when 0.
REQ-011 d_addr  input  16  data-side address.
REQ-012 d_wdata  input  16  data-side write data.
REQ-013 d_ready  output  1  data request accepted this cycle (transfer on d_req & d_ready).
REQ-014 d_valid  output  1  one-cycle pulse: read data valid or write complete.
REQ-015 d_rdata  output  16  data-side read data (0 for writes).
REQ-016 mem_enable  output  1  one-cycle issue strobe to main memory.
REQ-017 mem_wr  output  1  write qualifier, meaningful only with mem_enable.
REQ-018 mem_addr  output  16  latched address of the granted transaction.
REQ-019 mem_wdata  output  16  latched write data of the granted transaction.
REQ-020 mem_rdata  input  16  read data from main memory.
REQ-021 mem_data_valid  input  1  main memory read data valid.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-024 IDLE: i_ready/d_ready combinational, at most one high; if only one req high, that side gets ready; if both, D wins unless d_streak==2, then I wins.
REQ-025 d_streak (2-bit): +1 (saturate at 2) on a D grant while i_req high; cleared on any I grant or any cycle i_req low.
REQ-026 On acceptance: latch owner, d_wr (0 for I), address, write data; next state ISSUE.
REQ-027 ISSUE (one cycle): mem_enable=1, mem_wr=latched wr, mem_addr/mem_wdata=latched values; cycle counter loaded to 1; next WAIT.
REQ-028 WAIT, read: on mem_data_valid capture mem_rdata into owner's rdata register, go to RESP; no timeout.
REQ-029 WAIT, write: counter increments each cycle; when counter==MEM_LATENCY go to RESP; mem_data_valid ignored.
REQ-030 RESP (one cycle): owner's valid=1 with registered rdata; next IDLE; new acceptance possible only in the following IDLE cycle (minimum 1 idle cycle between transactions).
REQ-031 i_ready, d_ready SHALL be 0 in ISSUE, WAIT, RESP; requests arriving then remain pending.
REQ-032 mem_data_valid in IDLE, ISSUE, RESP or during a write SHALL be ignored.
REQ-033 Requester input changes after acceptance SHALL not affect the in-flight transaction.
REQ-034 i_rdata/d_rdata hold last captured value between pulses; d_rdata cleared to 0 at RESP of a write.
REQ-035 mem_enable SHALL be 0 in every state but ISSUE; mem_wr SHALL be 0 whenever mem_enable is 0.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, d_streak=0, counter=0, all outputs 0 (ready outputs then follow REQ-024 combinationally once rst_n high).
REQ-037 Reset mid-transaction SHALL abandon it with no valid pulse; any later mem_data_valid for it ignored per REQ-032.

Verification
REQ-038 I read: i_req=1, i_addr=0x0040 at T -> i_ready=1 at T, mem_enable=1/mem_wr=0/mem_addr=0x0040 at T+1; mem_data_valid with 0xBEEF at T+4 -> i_valid=1, i_rdata=0xBEEF at T+5, busy=0 at T+6.
REQ-039 D write, MEM_LATENCY=4: d_req=1, d_wr=1, d_addr=0x1000, d_wdata=0x1234 at T -> mem_enable=1, mem_wr=1, mem_wdata=0x1234 at T+1; d_valid=1, d_rdata=0 at T+5.
REQ-040 Contention: i_req and d_req held high continuously, d_wr=0 -> grant order D, D, I, D, D, I; i_ready and d_ready never both 1.
REQ-041 Spurious mem_data_valid=1 in IDLE and during a write -> no i_valid/d_valid pulse, write completes exactly at counter==MEM_LATENCY.
REQ-042 rst_n low during WAIT of a D read, then mem_data_valid arrives -> d_valid stays 0, busy=0, next d_req accepted in first IDLE cycle after reset release.
REQ-043 Request in RESP cycle: d_req rises while i-side in RESP -> d_ready=0 that cycle, d_ready=1 next (IDLE) cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter_if : requester and main-memory signal bundle for mem_arbiter   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ready;
  logic        i_valid;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    output i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata,
    output mem_enable, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    input  i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter : two-requester (I/D) arbiter, one outstanding memory access   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;
  localparam logic [3:0] c_LATENCY = 4'(MEM_LATENCY);

  logic [1:0]  r_state;
  logic        r_owner_d;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [1:0]  r_streak;
  logic [15:0] r_i_rdata;
  logic [15:0] r_d_rdata;

  logic        w_idle;
  logic        w_i_win;
  logic        w_i_grant;
  logic        w_d_grant;
  logic [3:0]  w_cnt_inc;

  // Data side wins ties until it has taken two grants in a row over a waiting I side.
  assign w_idle    = (r_state == c_IDLE);
  assign w_i_win   = bus.i_req & (~bus.d_req | (r_streak == 2'd2));
  assign w_i_grant = rst_n & w_idle & w_i_win;
  assign w_d_grant = rst_n & w_idle & bus.d_req & ~w_i_win;
  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= 16'd0;
      r_wdata   <= 16'd0;
      r_cnt     <= 4'd0;
      r_streak  <= 2'd0;
      r_i_rdata <= 16'd0;
      r_d_rdata <= 16'd0;
    end else begin
      if (w_i_grant || !bus.i_req) begin
        r_streak <= 2'd0;
      end else if (w_d_grant && (r_streak != 2'd2)) begin
        r_streak <= r_streak + 2'd1;
      end

      case (r_state)
        c_IDLE: begin
          if (w_i_grant) begin
            r_owner_d <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= bus.i_addr;
            r_wdata   <= 16'd0;
            r_state   <= c_ISSUE;
          end else if (w_d_grant) begin
            r_owner_d <= 1'b1;
            r_wr      <= bus.d_wr;
            r_addr    <= bus.d_addr;
            r_wdata   <= bus.d_wdata;
            r_state   <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_cnt   <= 4'd1;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          // Writes complete on a fixed latency; memory's valid strobe is only meaningful for reads.
          if (r_wr) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_LATENCY) begin
              r_d_rdata <= 16'd0;
              r_state   <= c_RESP;
            end
          end else if (bus.mem_data_valid) begin
            if (r_owner_d) begin
              r_d_rdata <= bus.mem_rdata;
            end else begin
              r_i_rdata <= bus.mem_rdata;
            end
            r_state <= c_RESP;
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.i_ready    = w_i_grant;
  assign bus.d_ready    = w_d_grant;
  assign bus.i_valid    = (r_state == c_RESP) & ~r_owner_d;
  assign bus.d_valid    = (r_state == c_RESP) & r_owner_d;
  assign bus.i_rdata    = r_i_rdata;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.mem_enable = (r_state == c_ISSUE);
  assign bus.mem_wr     = (r_state == c_ISSUE) & r_wr;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.busy       = ~w_idle;

endmodule

`default_nettype wire
